accel_mem_req_queue: RTL

Request queue between the accelerators and the data-memory arbiter's accelerator port. Buffers accelerator read/write requests in order, issues the head request only in cycles where the CPU does not own memory, and returns 512-bit read lines with a one-cycle valid pulse. CPU traffic keeps absolute priority; this block absorbs accelerator requests that would otherwise be lost.

---
 rtl/accel_memq_pkg.sv | 16 +
 rtl/accel_memq_fifo.sv | 42 ++++
 rtl/accel_mem_req_queue.sv | 95 +++++++++
 3 files changed

// File: rtl/accel_memq_pkg.sv
// accel_memq_pkg: shared types and default widths for the accelerator memory request queue
package accel_memq_pkg;
    localparam int MEMQ_DEPTH        = 4;
    localparam int MEMQ_ADDR_W       = 16;
    localparam int MEMQ_DATA_W       = 32;
    localparam int MEMQ_LINE_W       = 512;
    localparam int MEMQ_STARVE_LIMIT = 16;

    typedef struct packed {
        logic                   wrt;
        logic [MEMQ_ADDR_W-1:0] addr;
        logic [MEMQ_DATA_W-1:0] wrt_data;
    } memq_req_t;

    typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} memq_state_t;
endpackage

// File: rtl/accel_memq_fifo.sv
// accel_memq_fifo: in-order request storage with pointers, count, full/empty
module accel_memq_fifo
    import accel_memq_pkg::*;
#(
    parameter int DEPTH = MEMQ_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  memq_req_t                  wr_req,
    output memq_req_t                  head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    memq_req_t         mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= wr_req;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + PW'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + PW'(1) : rd_ptr;
            count  <= count + CW'(push) - CW'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
endmodule

// File: rtl/accel_mem_req_queue.sv
// accel_mem_req_queue: buffers accelerator requests, issues them when the CPU leaves memory idle.
// Optional starvation guard driving mem_prio_req is enabled with `define ACCEL_MEMQ_STARVE_EN.
module accel_mem_req_queue
    import accel_memq_pkg::*;
#(
    parameter int DEPTH        = MEMQ_DEPTH,
    parameter int ADDR_W       = MEMQ_ADDR_W,
    parameter int DATA_W       = MEMQ_DATA_W,
    parameter int LINE_W       = MEMQ_LINE_W,
    parameter int STARVE_LIMIT = MEMQ_STARVE_LIMIT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_wrt,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [DATA_W-1:0]          req_wrt_data,
    output logic                       rsp_valid,
    output logic [LINE_W-1:0]          rsp_data,
    input  logic                       cpu_busy,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wrt_data,
    output logic                       mem_wrt_en,
    input  logic [LINE_W-1:0]          mem_rd_data,
    output logic                       mem_prio_req,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int CW = $clog2(DEPTH+1);

    memq_state_t       state, state_nxt;
    memq_req_t         head;
    logic              push, pop, full, empty;
    logic [LINE_W-1:0] rsp_q;

    assign req_ready = !full;
    assign push      = req_valid && !full;
    assign pop       = state == ISSUE && !cpu_busy && !empty;

    accel_memq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push),
        .pop    (pop),
        .wr_req ('{wrt: req_wrt, addr: req_addr, wrt_data: req_wrt_data}),
        .head   (head),
        .full   (full),
        .empty  (empty),
        .count  (occupancy)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;

    // a push this cycle counts as occupancy so the request issues on the very next cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (push || !empty) ? ISSUE : IDLE;
            ISSUE:   if (pop) state_nxt = !head.wrt ? RD_WAIT :
                                          (occupancy > CW'(1) || push) ? ISSUE : IDLE;
            RD_WAIT: state_nxt = (push || !empty) ? ISSUE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_addr     = head.addr;
    assign mem_wrt_data = head.wrt_data;
    assign mem_wrt_en   = pop && head.wrt;

    // memory returns the line during RD_WAIT; forward it then, hold it afterwards
    assign rsp_valid = state == RD_WAIT;
    assign rsp_data  = rsp_valid ? mem_rd_data : rsp_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rsp_q <= '0;
        else if (rsp_valid) rsp_q <= mem_rd_data;

`ifdef ACCEL_MEMQ_STARVE_EN
    localparam int SW = $clog2(STARVE_LIMIT+1);
    logic [SW-1:0] starve_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) starve_cnt <= '0;
        else if (pop) starve_cnt <= '0;
        else if (state == ISSUE && cpu_busy && starve_cnt != SW'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + SW'(1);
    end

    assign mem_prio_req = starve_cnt >= SW'(STARVE_LIMIT);
`else
    assign mem_prio_req = 1'b0;
`endif
endmodule
